data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
- Byte-addressed data memory that responds to the processor's load/store requests and supplies READDATA to the write-back select path.
- Models a slow memory. BUSYWAIT stalls the CPU for a fixed LATENCY while an access is in progress.
- Single clock domain; sits beside the ALU/register file in the 8-bit single-cycle datapath.

Parameters:
- DATA_W, 8, data width in bits.
- ADDR_W, 8, address width; depth = 2**ADDR_W entries.
- LATENCY, 5, clock edges from request acceptance to access completion; legal range 1..15.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- READ  input  1  load request.
- WRITE  input  1  store request.
- ADDRESS  input  ADDR_W  byte address.
- WRITEDATA  input  DATA_W  store data.
- READDATA  output  DATA_W  load result; registered.
- BUSYWAIT  output  1  stall to CPU.

Behaviour:
- Reset (RESET low, asynchronous) sets: state IDLE, counter 0, READDATA 0, BUSYWAIT 0. Any access in flight is aborted; a pending write is not performed. Memory array contents are not cleared.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If exactly one of READ/WRITE is high, BUSYWAIT goes high combinationally in the same cycle.
  - At the next edge, ADDRESS, WRITEDATA and the op are latched, counter is loaded with LATENCY-1, and state moves to ACCESS.
  - If READ and WRITE are both high, the request is illegal: no access, BUSYWAIT stays 0, state stays IDLE.
- ACCESS:
  - BUSYWAIT is 1.
  - The counter decrements each edge.
  - At the edge where the counter equals 0, the access is performed and state moves to DONE:
    - Read: READDATA <= mem[latched addr].
    - Write: mem[latched addr] <= latched data; READDATA is unchanged.
- DONE:
  - BUSYWAIT is 0 for exactly one cycle.
  - READ/WRITE are ignored in this cycle, so the held request is not re-executed. This is the cycle in which the CPU advances.
  - Next edge returns to IDLE.
- Latency:
  - BUSYWAIT is high for LATENCY+1 cycles: the request cycle plus LATENCY cycles in ACCESS.
  - READDATA is valid from the edge entering DONE and is held until the next read completes.
- Input changes during ACCESS are ignored; only the values latched at acceptance are used.
- A request present in IDLE right after DONE starts a new access. Back-to-back accesses are therefore separated by the single DONE cycle.
- Address covers the full range 0..2**ADDR_W-1 with no wrap or out-of-range case.
- LATENCY=1: ACCESS lasts one cycle.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined:
  - Adds output ports READ_COUNT[15:0] and WRITE_COUNT[15:0].
  - Each counter increments on the edge entering DONE for its op type and saturates at 16'hFFFF.
  - Both counters are cleared by RESET.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package dmem_pkg:
  - State enum (IDLE, ACCESS, DONE).
  - Op type enum (OP_READ, OP_WRITE).
  - Default width/latency constants.
  - Saturation limit constant 16'hFFFF.
- Sub-module dmem_latency_counter:
  - Loadable down-counter with load and zero flag.
  - Same CLK and asynchronous active-low RESET.

Test Plan:
- Reset mid-access:
  - Stimulus: WRITE=1, ADDRESS=8'h20, WRITEDATA=8'h5A; pull RESET low on the 2nd ACCESS cycle.
  - Response: BUSYWAIT drops to 0 immediately; a later read of 8'h20 returns its prior value, not 8'h5A.
- Write then read, LATENCY=5:
  - Stimulus: WRITE=1, ADDRESS=8'h10, WRITEDATA=8'hA5.
  - Response: BUSYWAIT high for 6 cycles, then 0 for one DONE cycle.
  - Follow-up: READ 8'h10 returns READDATA=8'hA5 at the DONE edge, with BUSYWAIT high 6 cycles.
- Held request not re-executed:
  - Stimulus: keep WRITE=1 through the DONE cycle.
  - Response: exactly one write in DONE. Releasing WRITE on the DONE-cycle edge yields no second BUSYWAIT pulse; holding it starts a new access at the next IDLE.
- Illegal request:
  - Stimulus: READ=1 and WRITE=1 at ADDRESS=8'hFF.
  - Response: BUSYWAIT stays 0, memory and READDATA unchanged.
- Input change during access:
  - Stimulus: change ADDRESS from 8'h01 to 8'h02 during ACCESS of a read.
  - Response: READDATA is mem[8'h01]; boundary reads of 8'h00 and 8'hFF return their stored values.
- Stats (DMEM_STATS_EN defined):
  - Stimulus: 3 reads and 2 writes.
  - Response: READ_COUNT=3, WRITE_COUNT=2; force the counter to 16'hFFFF, do one more op, and it stays 16'hFFFF.

Source files
------------

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the slow byte-addressed data memory
// (data_memory_ctrl) and its latency counter.
//   state_t  : controller FSM states (IDLE, ACCESS, DONE)
//   op_t     : latched operation type (OP_READ, OP_WRITE)
//   DMEM_*   : default width/latency constants
//   CNT_W    : latency counter width (covers LATENCY 1..15)
//   STAT_MAX : saturation limit for the optional access statistics
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam int          DMEM_DATA_W  = 8;
  localparam int          DMEM_ADDR_W  = 8;
  localparam int          DMEM_LATENCY = 5;
  localparam int          CNT_W        = 4;
  localparam logic [15:0] STAT_MAX     = 16'hFFFF;

  // Increment that sticks at STAT_MAX instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == STAT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// -----------------------------------------------------------------------------
// data_memory_ctrl_if
// CPU <-> data memory load/store bus.
//   READ, WRITE  : request strobes (CPU -> memory)
//   ADDRESS      : byte address     (CPU -> memory)
//   WRITEDATA    : store data       (CPU -> memory)
//   READDATA     : load result      (memory -> CPU)
//   BUSYWAIT     : stall            (memory -> CPU)
// Modports: master (CPU side), slave (memory side).
// -----------------------------------------------------------------------------
interface data_memory_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              READ;
  logic              WRITE;
  logic [ADDR_W-1:0] ADDRESS;
  logic [DATA_W-1:0] WRITEDATA;
  logic [DATA_W-1:0] READDATA;
  logic              BUSYWAIT;

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA,
    input  READDATA, BUSYWAIT
  );

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA,
    output READDATA, BUSYWAIT
  );
endinterface

// File: rtl/dmem_latency_counter.sv
// -----------------------------------------------------------------------------
// dmem_latency_counter
// Loadable down-counter that times one memory access.
//   CLK        : clock, rising edge
//   RESET      : asynchronous active-low reset (counter -> 0)
//   load_i     : load load_val_i (takes priority over dec_i)
//   dec_i      : decrement by one, holding at zero
//   load_val_i : value to load
//   zero_o     : counter currently equals zero
// -----------------------------------------------------------------------------
module dmem_latency_counter
  import dmem_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// data_memory_ctrl
// Slow byte-addressed data memory for the 8-bit single-cycle datapath. A load
// or store is accepted in IDLE, takes LATENCY cycles in ACCESS, and completes
// into a one-cycle DONE state in which the CPU advances.
//   CLK         : clock, rising edge
//   RESET       : asynchronous active-low reset (aborts any access in flight)
//   bus         : data_memory_ctrl_if.slave (READ, WRITE, ADDRESS, WRITEDATA
//                 in; READDATA registered out, BUSYWAIT out)
//   READ_COUNT  : completed reads, saturating  (only with DMEM_STATS_EN)
//   WRITE_COUNT : completed writes, saturating (only with DMEM_STATS_EN)
// Optional feature macro: DMEM_STATS_EN adds the two statistics ports.
// -----------------------------------------------------------------------------
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic               CLK,
  input  logic               RESET,
  data_memory_ctrl_if.slave  bus
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]        READ_COUNT,
  output logic [15:0]        WRITE_COUNT
`endif
);

  localparam int               DEPTH    = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  state_t            state_q;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic req_valid;
  logic accept;
  logic in_access;
  logic cnt_zero;
  logic finish;
  logic mem_we;

  // READ and WRITE together is an illegal request and is simply not accepted.
  assign req_valid = bus.READ ^ bus.WRITE;
  assign accept    = (state_q == IDLE) && req_valid;
  assign in_access = (state_q == ACCESS);
  assign finish    = in_access && cnt_zero;
  assign mem_we    = finish && (op_q == OP_WRITE);

  dmem_latency_counter u_latency_counter (
    .CLK        (CLK),
    .RESET      (RESET),
    .load_i     (accept),
    .dec_i      (in_access),
    .load_val_i (LOAD_VAL),
    .zero_o     (cnt_zero)
  );

  // Controller FSM. Requests seen in DONE are deliberately ignored so a
  // request the CPU still holds is not executed a second time.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_q    <= bus.WRITE ? OP_WRITE : OP_READ;
            addr_q  <= bus.ADDRESS;
            wdata_q <= bus.WRITEDATA;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_zero) begin
            if (op_q == OP_READ) begin
              rdata_q <= mem_q[addr_q];
            end
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The array has no reset: contents survive RESET. The write strobe depends
  // on state_q, so an access aborted by reset never reaches the array.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  // Stall is raised combinationally in the request cycle so the CPU holds
  // immediately; it is forced low while reset is asserted.
  assign bus.BUSYWAIT = RESET && (in_access || accept);
  assign bus.READDATA = rdata_q;

`ifdef DMEM_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (finish) begin
      if (op_q == OP_READ) rd_cnt_d = sat_inc(rd_cnt_q);
      else                 wr_cnt_d = sat_inc(wr_cnt_q);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign READ_COUNT  = rd_cnt_q;
  assign WRITE_COUNT = wr_cnt_q;
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_memory_ctrl
// Scoreboard bench for data_memory_ctrl: expected load data is pushed when a
// read is issued and popped when the access completes. A reference array
// tracks memory contents. Statistics checks are built with DMEM_STATS_EN.
// -----------------------------------------------------------------------------
module tb_data_memory_ctrl;
  import dmem_pkg::*;

  localparam int LAT = 5;

  logic CLK;
  logic RESET;

  data_memory_ctrl_if #(.DATA_W(8), .ADDR_W(8)) bus ();

`ifdef DMEM_STATS_EN
  logic [15:0] READ_COUNT;
  logic [15:0] WRITE_COUNT;
`endif

  data_memory_ctrl #(
    .DATA_W  (8),
    .ADDR_W  (8),
    .LATENCY (LAT)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
`ifdef DMEM_STATS_EN
    ,
    .READ_COUNT  (READ_COUNT),
    .WRITE_COUNT (WRITE_COUNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] model [256];
  logic [7:0] exp_q [$];
  logic [7:0] last_rd;
  int         tb_rd;
  int         tb_wr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: drop request after acceptance and change ADDRESS/WRITEDATA
  //         to alt_a/~d during ACCESS
  // mode 1: hold request through DONE, release just after the edge leaving DONE
  // mode 2: hold request into the following IDLE; a second access must start
  task automatic do_op(input logic rd, input logic wr, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] alt_a,
                       input int mode, input string tag);
    int         busy;
    logic [7:0] exp;
    busy = 0;
    @(negedge CLK);
    bus.READ      = rd;
    bus.WRITE     = wr;
    bus.ADDRESS   = a;
    bus.WRITEDATA = d;
    if (rd) exp_q.push_back(model[a]);
    #1;
    while (bus.BUSYWAIT && busy < 40) begin
      busy++;
      @(negedge CLK);
      if (mode == 0) begin
        bus.READ      = 1'b0;
        bus.WRITE     = 1'b0;
        bus.ADDRESS   = alt_a;
        bus.WRITEDATA = ~d;
      end
      #1;
    end
    chk({tag, "_busy_cycles"}, busy, LAT + 1);
    if (rd) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_scoreboard_empty"}, 1, 0);
      end else begin
        exp = exp_q.pop_front();
        chk({tag, "_rdata"}, {24'd0, bus.READDATA}, {24'd0, exp});
        last_rd = exp;
      end
      tb_rd++;
    end
    if (wr) begin
      model[a] = d;
      chk({tag, "_rdata_kept"}, {24'd0, bus.READDATA}, {24'd0, last_rd});
      tb_wr++;
    end
    if (mode == 1) begin
      @(posedge CLK);
      #1;
      bus.READ  = 1'b0;
      bus.WRITE = 1'b0;
      @(negedge CLK); #1;
      chk({tag, "_no_repeat_a"}, {31'd0, bus.BUSYWAIT}, 0);
      @(negedge CLK); #1;
      chk({tag, "_no_repeat_b"}, {31'd0, bus.BUSYWAIT}, 0);
    end else if (mode == 2) begin
      @(negedge CLK); #1;
      chk({tag, "_restart"}, {31'd0, bus.BUSYWAIT}, 1);
      busy = 1;
      @(negedge CLK);
      bus.READ  = 1'b0;
      bus.WRITE = 1'b0;
      #1;
      while (bus.BUSYWAIT && busy < 40) begin
        busy++;
        @(negedge CLK); #1;
      end
      chk({tag, "_restart_busy_cycles"}, busy, LAT + 1);
      if (wr) tb_wr++;
      if (rd) tb_rd++;
    end
  endtask

  initial begin
    RESET         = 1'b0;
    bus.READ      = 1'b0;
    bus.WRITE     = 1'b0;
    bus.ADDRESS   = '0;
    bus.WRITEDATA = '0;
    last_rd       = 8'h00;
    tb_rd         = 0;
    tb_wr         = 0;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;

    repeat (3) @(negedge CLK);
    #1;
    chk("reset_busywait", {31'd0, bus.BUSYWAIT}, 0);
    chk("reset_readdata", {24'd0, bus.READDATA}, 0);
    RESET = 1'b1;

    // Write then read back
    do_op(1'b0, 1'b1, 8'h10, 8'hA5, 8'h10, 0, "wr10");
    do_op(1'b1, 1'b0, 8'h10, 8'h00, 8'h10, 0, "rd10");

    // Preload locations used below
    do_op(1'b0, 1'b1, 8'h20, 8'h33, 8'h20, 0, "wr20");
    do_op(1'b0, 1'b1, 8'h01, 8'h11, 8'h01, 0, "wr01");
    do_op(1'b0, 1'b1, 8'h02, 8'h22, 8'h02, 0, "wr02");
    do_op(1'b0, 1'b1, 8'h00, 8'h0F, 8'h00, 0, "wr00");
    do_op(1'b0, 1'b1, 8'hFF, 8'hF0, 8'hFF, 0, "wrFF");

    // Reset on the 2nd ACCESS cycle of a write
    @(negedge CLK);
    bus.WRITE     = 1'b1;
    bus.ADDRESS   = 8'h20;
    bus.WRITEDATA = 8'h5A;
    #1;
    chk("abort_req_busy", {31'd0, bus.BUSYWAIT}, 1);
    @(negedge CLK);
    @(negedge CLK);
    RESET     = 1'b0;
    bus.WRITE = 1'b0;
    #1;
    chk("abort_busy_drop", {31'd0, bus.BUSYWAIT}, 0);
    chk("abort_rdata_clr", {24'd0, bus.READDATA}, 0);
    last_rd = 8'h00;
    tb_rd   = 0;
    tb_wr   = 0;
    @(negedge CLK);
    RESET = 1'b1;
    do_op(1'b1, 1'b0, 8'h20, 8'h00, 8'h20, 0, "rd20_after_abort");

    // Held requests
    do_op(1'b0, 1'b1, 8'h30, 8'h77, 8'h30, 1, "hold_release");
    do_op(1'b0, 1'b1, 8'h31, 8'h88, 8'h31, 2, "hold_keep");

    // Illegal request: both strobes
    @(negedge CLK);
    bus.READ      = 1'b1;
    bus.WRITE     = 1'b1;
    bus.ADDRESS   = 8'hFF;
    bus.WRITEDATA = 8'h99;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("illegal_busy", {31'd0, bus.BUSYWAIT}, 0);
      @(negedge CLK);
    end
    bus.READ  = 1'b0;
    bus.WRITE = 1'b0;
    #1;
    chk("illegal_rdata", {24'd0, bus.READDATA}, {24'd0, last_rd});
    do_op(1'b1, 1'b0, 8'hFF, 8'h00, 8'hFF, 0, "rdFF_after_illegal");

    // Address change during ACCESS, plus boundary addresses
    do_op(1'b1, 1'b0, 8'h01, 8'h00, 8'h02, 0, "rd01_addr_change");
    do_op(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 0, "rd00");
    do_op(1'b1, 1'b0, 8'hFF, 8'h00, 8'hFF, 0, "rdFF");
    do_op(1'b1, 1'b0, 8'h31, 8'h00, 8'h31, 0, "rd31");

`ifdef DMEM_STATS_EN
    chk("stats_read_count", {16'd0, READ_COUNT}, tb_rd);
    chk("stats_write_count", {16'd0, WRITE_COUNT}, tb_wr);
    @(negedge CLK);
    force dut.rd_cnt_q = 16'hFFFF;
    force dut.wr_cnt_q = 16'hFFFF;
    @(negedge CLK);
    release dut.rd_cnt_q;
    release dut.wr_cnt_q;
    #1;
    chk("stats_forced_rd", {16'd0, READ_COUNT}, 32'h0000FFFF);
    do_op(1'b1, 1'b0, 8'h10, 8'h00, 8'h10, 0, "rd10_sat");
    do_op(1'b0, 1'b1, 8'h40, 8'h44, 8'h40, 0, "wr40_sat");
    chk("stats_rd_saturated", {16'd0, READ_COUNT}, 32'h0000FFFF);
    chk("stats_wr_saturated", {16'd0, WRITE_COUNT}, 32'h0000FFFF);
`endif

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
